otn_frame_sender: RTL
=====================

OTN_FRAME_SENDER -- requirements
Module: otn_frame_sender

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- FRAME_LEN, 16, bytes per frame.
- BIT_CLKS, 16, i_clk cycles per serial bit.
- ACK_TIMEOUT, 4096, cycles waited for an ACK after the last stop bit.
- MAX_RETRY, 3, retransmissions allowed before a frame is failed.
REQ-002 Ports, one per line (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_rst, in, 1, reset; synchronous, active-high.
- i_frame_data, in, 8, frame byte from the mapper.
- i_frame_valid, in, 1, i_frame_data is valid.
- o_frame_ready, out, 1, block accepts a byte this cycle.
- i_arq_en, in, 1, ACK/retransmit enable.
- o_otn_tx_data, out, 1, serial line to the receiver board.
- i_otn_rx_ack, in, 1, asynchronous ACK line from the receiver.
- o_busy, out, 1, a frame is being sent or acknowledged.
- o_frame_done, out, 1, one-cycle pulse: frame delivered.
- o_frame_fail, out, 1, one-cycle pulse: retries exhausted.
- o_retry_cnt, out, 2, retries used on the current frame.
REQ-003 Reset is i_rst, synchronous, active-high; clock is i_clk; all state updates on the rising edge of i_clk.

Function
REQ-004 States are LOAD, START, DATA, STOP, WAIT_ACK.
REQ-005 In LOAD the block shall assert o_frame_ready and store a byte into an internal FRAME_LEN x 8 buffer on every cycle with valid && ready.
REQ-006 o_frame_ready shall be 0 in every state other than LOAD.
REQ-007 On the cycle the FRAME_LEN-th byte is accepted, the block shall move to START with byte index 0, and o_busy shall rise on the next cycle.
REQ-008 Serial format per byte: one start bit (0), then 8 data bits LSB first, then one stop bit (1).
- Each bit is held exactly BIT_CLKS cycles.
- There is no idle gap between bytes.
- One frame therefore occupies FRAME_LEN*10*BIT_CLKS cycles.
REQ-009 The line shall be held at 1 in LOAD and WAIT_ACK.
REQ-010 After the last stop bit, transitions depend on i_arq_en:
- i_arq_en=1: go to WAIT_ACK.
- i_arq_en=0: pulse o_frame_done, clear o_retry_cnt, and return to LOAD.
REQ-011 i_arq_en shall be sampled once, at the end of the last stop bit; changes mid-frame have no effect on the current frame.
REQ-012 i_otn_rx_ack shall pass through a 2-flop synchronizer; ACK is a rising edge of the synchronized signal.
REQ-013 An ACK edge is acted on only in WAIT_ACK; edges in any other state are ignored and not remembered.
REQ-014 In WAIT_ACK a timeout counter shall start at 0 on entry and increment each cycle; ACK and timeout are resolved as follows:
- ACK before the counter reaches ACK_TIMEOUT-1: pulse o_frame_done, clear o_retry_cnt, go to LOAD.
- Counter reaches ACK_TIMEOUT-1 with no ACK and o_retry_cnt < MAX_RETRY: increment o_retry_cnt and go to START with byte index 0, resending the buffered frame unchanged.
- Counter reaches ACK_TIMEOUT-1 with no ACK and o_retry_cnt == MAX_RETRY: pulse o_frame_fail, clear o_retry_cnt, go to LOAD.
REQ-015 If an ACK edge and the timeout occur on the same cycle, the ACK shall win.
REQ-016 o_busy shall be 1 in START, DATA, STOP and WAIT_ACK, and 0 in LOAD.
REQ-017 o_frame_done and o_frame_fail shall never be asserted on the same cycle.
REQ-018 The bit counter, bit index and byte index shall each wrap to 0 on completion of their span; no counter may exceed its terminal value.
REQ-019 A partially loaded buffer shall persist across idle valid=0 cycles, with no load timeout.

Reset
REQ-020 While i_rst=1, outputs shall hold: o_otn_tx_data=1, o_frame_ready=0, o_busy=0, o_frame_done=0, o_frame_fail=0, o_retry_cnt=0.
REQ-021 On release of reset, the state shall be LOAD, the load count 0, and the synchronizer flops 0; o_frame_ready shall be 1 on the first cycle after release.
REQ-022 Reset asserted mid-frame or in WAIT_ACK shall abort the frame with no done/fail pulse, and the line shall return to 1 on the next edge.

Verification
REQ-023 The bench shall cover these scenarios (FRAME_LEN=4 and BIT_CLKS=4 unless noted):
- Basic frame, i_arq_en=0, bytes 0xA5,0x01,0xFF,0x00: line carries 0,1,0,1,0,0,1,0,1,1 for the first byte, 4 cycles per bit; o_frame_done pulses 160 cycles after START entry; o_frame_ready returns to 1.
- i_arq_en=1, ACK raised 10 cycles after the last stop bit: exactly one o_frame_done, o_retry_cnt=0, no retransmission.
- i_arq_en=1, ACK_TIMEOUT=32, no ACK: 4 identical transmissions, o_retry_cnt steps 1,2,3, then o_frame_fail pulses once and the block is back in LOAD.
- ACK rising edge during DATA, then none in WAIT_ACK: the edge is ignored and a retransmission occurs after ACK_TIMEOUT.
- ACK edge timed to coincide with the timeout cycle: o_frame_done pulses and o_retry_cnt stays 0.
- i_rst pulsed during byte 2: line returns to 1, no done/fail pulse, and a subsequent full frame transmits correctly.

Source files
------------

// File: rtl/otn_frame_sender.sv
// otn_frame_sender: buffers one frame of FRAME_LEN bytes and sends it on a
// single serial line (start 0, 8 data bits LSB first, stop 1, BIT_CLKS
// cycles per bit). With i_arq_en set at frame end, waits for an ACK edge and
// retransmits on timeout up to MAX_RETRY times.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_frame_data/_valid  byte input from the mapper; o_frame_ready handshake
//   i_arq_en             ACK/retransmit enable, sampled at end of frame
//   o_otn_tx_data        serial line (idles at 1)
//   i_otn_rx_ack         asynchronous ACK line
//   o_busy               frame in flight or awaiting ACK
//   o_frame_done/_fail   one-cycle completion pulses
//   o_retry_cnt          retransmissions used on the current frame
module otn_frame_sender #(
  parameter int unsigned FRAME_LEN   = 16,
  parameter int unsigned BIT_CLKS    = 16,
  parameter int unsigned ACK_TIMEOUT = 4096,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_frame_data,
  input  logic       i_frame_valid,
  output logic       o_frame_ready,
  input  logic       i_arq_en,
  output logic       o_otn_tx_data,
  input  logic       i_otn_rx_ack,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_frame_fail,
  output logic [1:0] o_retry_cnt
);

  localparam int unsigned LD_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned BC_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int unsigned TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_LOAD, S_START, S_DATA, S_STOP, S_WAIT_ACK
  } state_t;

  state_t          state_q, state_d;
  logic [LD_W-1:0] load_cnt_q, load_cnt_d;
  logic [LD_W-1:0] byte_idx_q, byte_idx_d;
  logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]      retry_q, retry_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic            ack_meta_q, ack_sync_q, ack_prev_q;
  logic [7:0]      buf_q [FRAME_LEN];
  logic            wr_en;
  logic            ack_edge;
  logic            bit_end;
  logic [7:0]      cur_byte;

  assign ack_edge = ack_sync_q & ~ack_prev_q;
  assign bit_end  = (bit_cnt_q == BC_W'(BIT_CLKS - 1));
  assign cur_byte = buf_q[byte_idx_d];

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_LOAD;
      load_cnt_q <= '0;
      byte_idx_q <= '0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      to_cnt_q   <= '0;
      retry_q    <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
      ack_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      byte_idx_q <= byte_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      to_cnt_q   <= to_cnt_d;
      retry_q    <= retry_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      ack_meta_q <= i_otn_rx_ack;
      ack_sync_q <= ack_meta_q;
      ack_prev_q <= ack_sync_q;
    end
  end

  // Frame buffer; kept intact across retransmissions
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      buf_q[load_cnt_q] <= i_frame_data;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    byte_idx_d = byte_idx_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    to_cnt_d   = to_cnt_q;
    retry_d    = retry_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    wr_en      = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        if (i_frame_valid && ready_q) begin
          wr_en = 1'b1;
          if (load_cnt_q == LD_W'(FRAME_LEN - 1)) begin
            load_cnt_d = '0;
            byte_idx_d = '0;
            bit_cnt_d  = '0;
            state_d    = S_START;
          end else begin
            load_cnt_d = load_cnt_q + LD_W'(1);
          end
        end
      end
      S_START: begin
        bit_cnt_d = bit_end ? '0 : bit_cnt_q + BC_W'(1);
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        bit_cnt_d = bit_end ? '0 : bit_cnt_q + BC_W'(1);
        if (bit_end) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        bit_cnt_d = bit_end ? '0 : bit_cnt_q + BC_W'(1);
        if (bit_end) begin
          if (byte_idx_q == LD_W'(FRAME_LEN - 1)) begin
            byte_idx_d = '0;
            // ARQ mode is decided here, once per frame
            if (i_arq_en) begin
              to_cnt_d = '0;
              state_d  = S_WAIT_ACK;
            end else begin
              done_d  = 1'b1;
              retry_d = '0;
              state_d = S_LOAD;
            end
          end else begin
            byte_idx_d = byte_idx_q + LD_W'(1);
            state_d    = S_START;
          end
        end
      end
      S_WAIT_ACK: begin
        // ACK takes priority over a coincident timeout
        if (ack_edge) begin
          done_d  = 1'b1;
          retry_d = '0;
          state_d = S_LOAD;
        end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
          to_cnt_d = '0;
          if (retry_q < 2'(MAX_RETRY)) begin
            retry_d    = retry_q + 2'd1;
            byte_idx_d = '0;
            bit_cnt_d  = '0;
            state_d    = S_START;
          end else begin
            fail_d  = 1'b1;
            retry_d = '0;
            state_d = S_LOAD;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Registered outputs follow the next state so they align with state_q
  always_comb begin
    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d != S_LOAD);
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign o_frame_ready = ready_q;
  assign o_otn_tx_data = tx_q;
  assign o_busy        = busy_q;
  assign o_frame_done  = done_q;
  assign o_frame_fail  = fail_q;
  assign o_retry_cnt   = retry_q;

endmodule
